// File: rtl/spi_shadow_regbank.sv
// spi_shadow_regbank
// Register bank and commit controller that sits behind the SPI slave.
// Writes from the slave land in a shadow register set. A commit command
// copies every shadow register to the live outputs on one sclk edge, so
// downstream PWM settings never see a half-updated configuration.
// The bank also supports a discard command, a sticky lock and a
// saturating error counter.
//
// Ports:
//   sclk           in   SPI clock, all state updates on its rising edge
//   rst_n          in   asynchronous active-low reset
//   addr_i         in   register address, bit 7 ignored
//   data_wr_i      in   write data
//   wr_en_i        in   level write strobe, may stay high several edges
//   data_rd_o      out  combinational read data
//   active_o       out  live registers, reg k at bits [8k+7:8k]
//   commit_pulse_o out  high for one sclk cycle after a commit
//   locked_o       out  sticky lock status
module spi_shadow_regbank #(
   parameter int         NREG      = 8,
   parameter logic [6:0] ADDR_CTRL = 7'h7E,
   parameter logic [6:0] ADDR_STAT = 7'h7F
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic [7:0]        addr_i,
   input  logic [7:0]        data_wr_i,
   input  logic              wr_en_i,
   output logic [7:0]        data_rd_o,
   output logic [NREG*8-1:0] active_o,
   output logic              commit_pulse_o,
   output logic              locked_o
);

   logic [7:0] shadow [NREG];
   logic [7:0] active [NREG];
   logic       dirty;
   logic [3:0] err_cnt;
   logic       wr_en_q;

   logic [6:0] a;
   logic       accept;
   logic       a_is_data;
   logic       unused_addr_msb;

   assign a               = addr_i[6:0];
   assign unused_addr_msb = addr_i[7];

   // The slave holds wr_en_i high for as long as it likes, so only the
   // rising edge of the strobe counts as a write.
   assign accept = wr_en_i & ~wr_en_q;

   // Address falls inside the data register window.
   always_comb begin
      a_is_data = 1'b0;
      for (int k = 0; k < NREG; k++) begin
         if (a == 7'(k)) a_is_data = 1'b1;
      end
   end

   // Main state update. The mode machine is kept as two flags: dirty
   // (shadow differs from what was last committed/discarded) and locked.
   // UNLOCKED_CLEAN/UNLOCKED_DIRTY map to locked=0 with dirty=0/1, and
   // LOCKED keeps tracking dirty because commit/discard stay legal.
   // Discard has priority over commit; lock is applied after either, on
   // the same edge, and is only cleared by reset.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREG; k++) begin
            shadow[k] <= 8'h00;
            active[k] <= 8'h00;
         end
         dirty          <= 1'b0;
         locked_o       <= 1'b0;
         err_cnt        <= 4'h0;
         commit_pulse_o <= 1'b0;
         wr_en_q        <= 1'b0;
      end else begin
         wr_en_q        <= wr_en_i;
         commit_pulse_o <= 1'b0;
         if (accept) begin
            if (a == ADDR_STAT) begin
               err_cnt <= 4'h0;
            end else if (a == ADDR_CTRL) begin
               if (data_wr_i[1]) begin
                  for (int k = 0; k < NREG; k++) shadow[k] <= active[k];
                  dirty <= 1'b0;
               end else if (data_wr_i[0]) begin
                  for (int k = 0; k < NREG; k++) active[k] <= shadow[k];
                  dirty          <= 1'b0;
                  commit_pulse_o <= 1'b1;
               end
               if (data_wr_i[2]) locked_o <= 1'b1;
            end else if (a_is_data && !locked_o) begin
               for (int k = 0; k < NREG; k++) begin
                  if (a == 7'(k)) shadow[k] <= data_wr_i;
               end
               dirty <= 1'b1;
            end else begin
               if (err_cnt != 4'hF) err_cnt <= err_cnt + 4'h1;
            end
         end
      end
   end

   // Flatten the live registers onto the output bus.
   always_comb begin
      active_o = '0;
      for (int k = 0; k < NREG; k++) active_o[8*k +: 8] = active[k];
   end

   // Read mux back to the slave; data reads return the shadow copy so the
   // host can verify what it is about to commit.
   always_comb begin
      data_rd_o = 8'h00;
      if (a == ADDR_CTRL) begin
         data_rd_o = {7'b0, locked_o};
      end else if (a == ADDR_STAT) begin
         data_rd_o = {locked_o, dirty, 2'b00, err_cnt};
      end else begin
         for (int k = 0; k < NREG; k++) begin
            if (a == 7'(k)) data_rd_o = shadow[k];
         end
      end
   end

endmodule

// File: tb/tb_spi_shadow_regbank.sv
// tb_spi_shadow_regbank
// Directed self-checking bench for spi_shadow_regbank with NREG = 8.
// Inputs change on the falling edge of sclk, outputs are observed on the
// falling edge or a short delay after it.
module tb_spi_shadow_regbank;

   logic        sclk;
   logic        rst_n;
   logic [7:0]  addr_i;
   logic [7:0]  data_wr_i;
   logic        wr_en_i;
   logic [7:0]  data_rd_o;
   logic [63:0] active_o;
   logic        commit_pulse_o;
   logic        locked_o;

   int checkCount = 0;
   int errorCount = 0;

   spi_shadow_regbank #(.NREG(8)) dut (
      .sclk           (sclk),
      .rst_n          (rst_n),
      .addr_i         (addr_i),
      .data_wr_i      (data_wr_i),
      .wr_en_i        (wr_en_i),
      .data_rd_o      (data_rd_o),
      .active_o       (active_o),
      .commit_pulse_o (commit_pulse_o),
      .locked_o       (locked_o)
   );

   // Free-running 10 ns SPI clock.
   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   // Single comparison point: counts every check, reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // One write: strobe high for exactly one rising edge. Returns on the
   // falling edge just after the accepting edge.
   task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
      @(negedge sclk);
      addr_i    = addr;
      data_wr_i = data;
      wr_en_i   = 1'b1;
      @(negedge sclk);
      wr_en_i   = 1'b0;
   endtask

   task automatic readReg(input logic [7:0] addr, output logic [7:0] data);
      addr_i = addr;
      #1;
      data = data_rd_o;
   endtask

   logic [7:0] rd;

   initial begin
      rst_n     = 1'b0;
      addr_i    = 8'h00;
      data_wr_i = 8'h00;
      wr_en_i   = 1'b0;
      repeat (2) @(negedge sclk);

      // Reset state
      checkOutput("rst_active", active_o, 64'h0);
      checkOutput("rst_pulse", commit_pulse_o, 0);
      checkOutput("rst_locked", locked_o, 0);
      readReg(8'h7F, rd);
      checkOutput("rst_stat", rd, 8'h00);
      rst_n = 1'b1;

      // Shadow write, then commit
      applyStimulus(8'h02, 8'h5A);
      readReg(8'h02, rd);
      checkOutput("rd_shadow2", rd, 8'h5A);
      checkOutput("active_before_commit", active_o, 64'h0);
      readReg(8'h7F, rd);
      checkOutput("stat_dirty", rd, 8'h40);
      applyStimulus(8'h7E, 8'h01);
      checkOutput("commit_pulse_hi", commit_pulse_o, 1);
      checkOutput("active_after_commit", active_o, 64'h0000_0000_005A_0000);
      @(negedge sclk);
      checkOutput("commit_pulse_lo", commit_pulse_o, 0);
      readReg(8'h7F, rd);
      checkOutput("stat_clean", rd, 8'h00);

      // Held strobe: only the first edge may write; data changes later
      @(negedge sclk);
      addr_i = 8'h03; data_wr_i = 8'h10; wr_en_i = 1'b1;
      @(negedge sclk);
      data_wr_i = 8'h99;
      repeat (4) @(negedge sclk);
      wr_en_i = 1'b0;
      readReg(8'h03, rd);
      checkOutput("held_strobe_one_write", rd, 8'h10);

      // Out-of-range write counts as an error
      applyStimulus(8'h09, 8'h77);
      readReg(8'h7F, rd);
      checkOutput("stat_err1", rd, 8'h41);
      readReg(8'h09, rd);
      checkOutput("rd_unmapped", rd, 8'h00);

      // Discard beats commit in the same byte
      applyStimulus(8'h00, 8'hFF);
      applyStimulus(8'h7E, 8'h03);
      checkOutput("discard_no_pulse", commit_pulse_o, 0);
      checkOutput("discard_active", active_o, 64'h0000_0000_005A_0000);
      readReg(8'h00, rd);
      checkOutput("discard_shadow0", rd, 8'h00);
      readReg(8'h03, rd);
      checkOutput("discard_shadow3", rd, 8'h00);
      readReg(8'h7F, rd);
      checkOutput("discard_stat", rd, 8'h01);

      // Clear errors, then commit-and-lock
      applyStimulus(8'h7F, 8'h00);
      applyStimulus(8'h01, 8'h22);
      applyStimulus(8'h7E, 8'h05);
      checkOutput("lock_commit_pulse", commit_pulse_o, 1);
      checkOutput("lock_commit_active", active_o, 64'h0000_0000_005A_2200);
      checkOutput("locked", locked_o, 1);
      readReg(8'h7E, rd);
      checkOutput("rd_ctrl", rd, 8'h01);
      readReg(8'h7F, rd);
      checkOutput("stat_locked", rd, 8'h80);

      // Data write while locked is dropped
      applyStimulus(8'h01, 8'h33);
      readReg(8'h01, rd);
      checkOutput("locked_write_dropped", rd, 8'h22);
      readReg(8'h7F, rd);
      checkOutput("stat_locked_err", rd, 8'h81);

      // STAT write with bit 7 set still clears errors
      applyStimulus(8'hFF, 8'h00);
      readReg(8'h7F, rd);
      checkOutput("stat_clear_locked", rd, 8'h80);

      // Commit remains legal while locked
      applyStimulus(8'h7E, 8'h01);
      checkOutput("locked_commit_pulse", commit_pulse_o, 1);

      // Error counter saturation
      for (int i = 0; i < 14; i++) applyStimulus(8'h40, 8'h00);
      readReg(8'h7F, rd);
      checkOutput("err_14", rd, 8'h8E);
      for (int i = 0; i < 6; i++) applyStimulus(8'h01, 8'h00);
      readReg(8'h7F, rd);
      checkOutput("err_saturated", rd, 8'h8F);

      // Reset between strobe rise and the sampling edge
      @(negedge sclk);
      addr_i = 8'h00; data_wr_i = 8'hAA; wr_en_i = 1'b1;
      #2 rst_n = 1'b0;
      @(posedge sclk);
      #1;
      checkOutput("midrst_active", active_o, 64'h0);
      checkOutput("midrst_locked", locked_o, 0);
      checkOutput("midrst_pulse", commit_pulse_o, 0);
      readReg(8'h00, rd);
      checkOutput("midrst_shadow0", rd, 8'h00);
      readReg(8'h7F, rd);
      checkOutput("midrst_stat", rd, 8'h00);
      @(negedge sclk);
      wr_en_i = 1'b0;
      @(negedge sclk);
      rst_n = 1'b1;

      // Writes work normally after reset
      applyStimulus(8'h00, 8'hAA);
      readReg(8'h00, rd);
      checkOutput("post_rst_write", rd, 8'hAA);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
